exec_cond_stage: RTL and testbench

EXEC_COND_STAGE -- requirements
Module: exec_cond_stage

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/exec_cond_stage_if.sv | 50 +++++
 rtl/exec_cond_stage_cond_check.sv | 40 ++++
 rtl/exec_cond_stage.sv | 85 ++++++++
 tb/tb_exec_cond_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ARM condition codes, NZCV flag bit positions and
// the control bundle carried from the execute stage into the memory stage.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memwrite;
    logic memtoreg;
  } m_ctrl_t;

endpackage

// File: rtl/exec_cond_stage_if.sv
// Bundle between the execute stage and its neighbours. There is no valid/ready
// handshake here: EN = 0 stalls (M outputs and flags hold), CLR = 1 flushes the
// M stage to a bubble on the next edge and wins over EN.
interface exec_cond_stage_if #(parameter int BITS = 32);

  logic            EN;
  logic            CLR;
  logic [3:0]      CondE;
  logic [1:0]      FlagWriteE;
  logic [3:0]      ALUFlags;
  logic            PCSrcE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            MemtoRegE;
  logic            BranchE;
  logic            NoWriteE;
  logic [BITS-1:0] ALUResultE;
  logic [BITS-1:0] WriteDataE;
  logic [3:0]      WA3E;

  logic            CondExE;
  logic            BranchTakenE;
  logic [3:0]      FlagsR;
  logic            PCSrcM;
  logic            RegWriteM;
  logic            MemWriteM;
  logic            MemtoRegM;
  logic [BITS-1:0] ALUResultM;
  logic [BITS-1:0] WriteDataM;
  logic [3:0]      WA3M;

  modport master (
    output EN, CLR, CondE, FlagWriteE, ALUFlags,
    output PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, NoWriteE,
    output ALUResultE, WriteDataE, WA3E,
    input  CondExE, BranchTakenE, FlagsR,
    input  PCSrcM, RegWriteM, MemWriteM, MemtoRegM,
    input  ALUResultM, WriteDataM, WA3M
  );

  modport slave (
    input  EN, CLR, CondE, FlagWriteE, ALUFlags,
    input  PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, NoWriteE,
    input  ALUResultE, WriteDataE, WA3E,
    output CondExE, BranchTakenE, FlagsR,
    output PCSrcM, RegWriteM, MemWriteM, MemtoRegM,
    output ALUResultM, WriteDataM, WA3M
  );

endinterface

// File: rtl/exec_cond_stage_cond_check.sv
// Combinational ARM condition evaluation of a 4-bit condition field against
// the NZCV flags; NV (4'b1111) never executes.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: ex = z;
      COND_NE: ex = ~z;
      COND_CS: ex = c;
      COND_CC: ex = ~c;
      COND_MI: ex = n;
      COND_PL: ex = ~n;
      COND_VS: ex = v;
      COND_VC: ex = ~v;
      COND_HI: ex = c & ~z;
      COND_LS: ex = ~c | z;
      COND_GE: ex = (n == v);
      COND_LT: ex = (n != v);
      COND_GT: ex = ~z & (n == v);
      COND_LE: ex = z | (n != v);
      COND_AL: ex = 1'b1;
      default: ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cond_stage.sv
// Execute-stage condition unit: evaluates the condition field, owns the NZCV
// flag register and the E->M pipeline register with stall and flush.
module exec_cond_stage
  import cpu_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  exec_cond_stage_if.slave    bus
);

  logic            cond_ex;
  logic [3:0]      flags_d, flags_q;
  m_ctrl_t         ctrl_d, ctrl_q;
  logic [BITS-1:0] alu_result_d, alu_result_q;
  logic [BITS-1:0] write_data_d, write_data_q;
  logic [3:0]      wa3_d, wa3_q;

  cond_check u_cond_check (
    .cond  (bus.CondE),
    .flags (flags_q),
    .ex    (cond_ex)
  );

  // Flags are read directly from the register, so an instruction that sets
  // flags is seen by the very next instruction without any bypass.
  always_comb begin
    flags_d      = flags_q;
    ctrl_d       = ctrl_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    wa3_d        = wa3_q;
    if (bus.CLR) begin
      ctrl_d       = '0;
      alu_result_d = '0;
      write_data_d = '0;
      wa3_d        = '0;
    end else if (bus.EN) begin
      ctrl_d.pcsrc    = bus.PCSrcE & cond_ex;
      ctrl_d.regwrite = bus.RegWriteE & cond_ex & ~bus.NoWriteE;
      ctrl_d.memwrite = bus.MemWriteE & cond_ex;
      ctrl_d.memtoreg = bus.MemtoRegE;
      alu_result_d    = bus.ALUResultE;
      write_data_d    = bus.WriteDataE;
      wa3_d           = bus.WA3E;
      if (cond_ex && bus.FlagWriteE[1]) begin
        flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
        flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
      end
      if (cond_ex && bus.FlagWriteE[0]) begin
        flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
        flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flags_q      <= '0;
      ctrl_q       <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      wa3_q        <= '0;
    end else begin
      flags_q      <= flags_d;
      ctrl_q       <= ctrl_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      wa3_q        <= wa3_d;
    end
  end

  assign bus.CondExE      = cond_ex;
  assign bus.BranchTakenE = bus.BranchE & cond_ex;
  assign bus.FlagsR       = flags_q;
  assign bus.PCSrcM       = ctrl_q.pcsrc;
  assign bus.RegWriteM    = ctrl_q.regwrite;
  assign bus.MemWriteM    = ctrl_q.memwrite;
  assign bus.MemtoRegM    = ctrl_q.memtoreg;
  assign bus.ALUResultM   = alu_result_q;
  assign bus.WriteDataM   = write_data_q;
  assign bus.WA3M         = wa3_q;

endmodule

// File: tb/tb_exec_cond_stage.sv
// Bench for exec_cond_stage: hand-computed vector table, randomized traffic
// against a flag/M-register model, plus reset and stall/flush sequences.
module tb_exec_cond_stage;

  typedef struct {
    logic        en, clr;
    logic [3:0]  cond;
    logic [1:0]  fw;
    logic [3:0]  af;
    logic        pcsrc, regw, memw, m2r, branch, nowrite;
    logic [31:0] alu, wd;
    logic [3:0]  wa3;
    logic        exp_cx;
    logic [3:0]  exp_flags;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [71:0] exp_q[$];
  logic [71:0] m_model;
  logic [3:0]  flags_model;
  vec_t        vecs[$];

  exec_cond_stage_if #(.BITS(32)) bus ();

  exec_cond_stage #(.BITS(32)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cond_model(input logic [3:0] cond, input logic [3:0] f);
    logic base;
    case (cond[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] & ~f[2];
      3'd5: base = (f[3] == f[0]);
      3'd6: base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  function automatic logic [71:0] dut_m();
    return {bus.PCSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM,
            bus.ALUResultM, bus.WriteDataM, bus.WA3M};
  endfunction

  function automatic vec_t mk(input logic en, clr, input logic [3:0] cond,
                              input logic [1:0] fw, input logic [3:0] af,
                              input logic pcsrc, regw, memw, m2r, branch, nowrite,
                              input logic [31:0] alu, wd, input logic [3:0] wa3,
                              input logic exp_cx, input logic [3:0] exp_flags);
    vec_t v;
    v.en = en; v.clr = clr; v.cond = cond; v.fw = fw; v.af = af;
    v.pcsrc = pcsrc; v.regw = regw; v.memw = memw; v.m2r = m2r;
    v.branch = branch; v.nowrite = nowrite;
    v.alu = alu; v.wd = wd; v.wa3 = wa3;
    v.exp_cx = exp_cx; v.exp_flags = exp_flags;
    return v;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.EN = v.en; bus.CLR = v.clr; bus.CondE = v.cond;
    bus.FlagWriteE = v.fw; bus.ALUFlags = v.af;
    bus.PCSrcE = v.pcsrc; bus.RegWriteE = v.regw; bus.MemWriteE = v.memw;
    bus.MemtoRegE = v.m2r; bus.BranchE = v.branch; bus.NoWriteE = v.nowrite;
    bus.ALUResultE = v.alu; bus.WriteDataE = v.wd; bus.WA3E = v.wa3;
  endtask

  // Drive one cycle, check combinational outputs, update model, push the
  // expected M contents, then pop and compare after the edge.
  task automatic step(input vec_t v, input string tag);
    logic cx;
    logic [71:0] exp_m;
    drive(v);
    #1;
    cx = cond_model(v.cond, flags_model);
    check({tag, " CondExE"}, 72'(bus.CondExE), 72'(cx));
    check({tag, " BranchTakenE"}, 72'(bus.BranchTakenE), 72'(v.branch & cx));
    if (v.clr) begin
      m_model = '0;
    end else if (v.en) begin
      m_model = {v.pcsrc & cx, v.regw & cx & ~v.nowrite, v.memw & cx, v.m2r,
                 v.alu, v.wd, v.wa3};
      if (cx && v.fw[1]) flags_model[3:2] = v.af[3:2];
      if (cx && v.fw[0]) flags_model[1:0] = v.af[1:0];
    end
    exp_q.push_back(m_model);
    @(posedge clk);
    #1;
    exp_m = exp_q.pop_front();
    check({tag, " M regs"}, dut_m(), exp_m);
    check({tag, " FlagsR"}, 72'(bus.FlagsR), 72'(flags_model));
  endtask

  initial begin
    vec_t v;
    checks = 0;
    failures = 0;
    flags_model = '0;
    m_model = '0;
    rst_n = 1'b0;
    drive(mk(1, 0, 4'd14, 2'b11, 4'hF, 1, 1, 1, 1, 1, 0, 32'hFFFF, 32'hEEEE, 4'hF, 1, 4'h0));

    // Reset: state cleared with clock running and inputs active
    repeat (3) @(posedge clk);
    #2;
    check("reset FlagsR", 72'(bus.FlagsR), 72'h0);
    check("reset M regs", dut_m(), 72'h0);
    check("reset CondExE(AL)", 72'(bus.CondExE), 72'h1);
    @(negedge clk);
    bus.EN = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Columns: en clr cond fw af | pcsrc regw memw m2r branch nowrite | alu wd wa3 | exp_cx exp_flags
    vecs.push_back(mk(1, 0, 4'd0,  2'b00, 4'h0, 0, 0, 1, 0, 1, 0, 32'h11, 32'h22, 4'd3, 0, 4'h0));
    vecs.push_back(mk(1, 0, 4'd14, 2'b11, 4'h6, 0, 1, 0, 0, 0, 0, 32'h0,  32'h33, 4'd4, 1, 4'h6));
    vecs.push_back(mk(1, 0, 4'd1,  2'b00, 4'h0, 0, 1, 0, 0, 0, 0, 32'h5,  32'h44, 4'd5, 0, 4'h6));
    vecs.push_back(mk(1, 0, 4'd0,  2'b01, 4'h1, 0, 1, 0, 0, 0, 0, 32'h5,  32'h55, 4'd6, 1, 4'h5));
    vecs.push_back(mk(1, 0, 4'd14, 2'b11, 4'h1, 1, 0, 0, 0, 0, 0, 32'h7,  32'h66, 4'd7, 1, 4'h1));
    vecs.push_back(mk(1, 0, 4'd14, 2'b10, 4'hB, 0, 1, 1, 1, 0, 0, 32'h8,  32'h77, 4'd8, 1, 4'h9));
    vecs.push_back(mk(0, 0, 4'd10, 2'b11, 4'hF, 1, 1, 1, 1, 0, 0, 32'h9,  32'h88, 4'd9, 1, 4'h9));
    vecs.push_back(mk(1, 0, 4'd11, 2'b11, 4'hF, 1, 1, 0, 0, 0, 0, 32'hA,  32'h99, 4'd10, 0, 4'h9));
    vecs.push_back(mk(1, 1, 4'd12, 2'b11, 4'h2, 1, 1, 1, 1, 0, 0, 32'hB,  32'hAA, 4'd11, 1, 4'h9));
    vecs.push_back(mk(1, 0, 4'd9,  2'b01, 4'h2, 1, 1, 0, 1, 0, 1, 32'hC,  32'hBB, 4'd12, 1, 4'hA));
    vecs.push_back(mk(1, 0, 4'd8,  2'b00, 4'h0, 0, 0, 0, 0, 1, 0, 32'hD,  32'hCC, 4'd13, 1, 4'hA));
    vecs.push_back(mk(1, 0, 4'd15, 2'b11, 4'h0, 1, 1, 1, 0, 1, 0, 32'hE,  32'hDD, 4'd14, 0, 4'hA));
    vecs.push_back(mk(1, 0, 4'd3,  2'b00, 4'h0, 0, 0, 1, 0, 0, 0, 32'hF,  32'hEE, 4'd15, 0, 4'hA));
    vecs.push_back(mk(1, 0, 4'd13, 2'b11, 4'h4, 0, 0, 0, 0, 0, 0, 32'h10, 32'hFF, 4'd1, 1, 4'h4));
    vecs.push_back(mk(1, 0, 4'd0,  2'b00, 4'h0, 0, 1, 0, 0, 0, 0, 32'h5,  32'h1,  4'd2, 1, 4'h4));
    vecs.push_back(mk(1, 0, 4'd5,  2'b00, 4'h0, 0, 1, 0, 0, 0, 0, 32'h6,  32'h2,  4'd3, 1, 4'h4));
    vecs.push_back(mk(1, 0, 4'd7,  2'b00, 4'h0, 0, 0, 1, 0, 0, 0, 32'h7,  32'h3,  4'd4, 1, 4'h4));
    vecs.push_back(mk(1, 0, 4'd4,  2'b00, 4'h0, 1, 0, 0, 0, 1, 0, 32'h8,  32'h4,  4'd5, 0, 4'h4));
    vecs.push_back(mk(1, 0, 4'd6,  2'b00, 4'h0, 0, 0, 1, 0, 0, 0, 32'h9,  32'h5,  4'd6, 0, 4'h4));
    vecs.push_back(mk(1, 0, 4'd2,  2'b00, 4'h0, 0, 1, 0, 0, 0, 0, 32'hA,  32'h6,  4'd7, 0, 4'h4));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d table CondExE", i), 72'(bus.CondExE), 72'(vecs[i].exp_cx));
      step(vecs[i], $sformatf("vec%0d", i));
      check($sformatf("vec%0d table FlagsR", i), 72'(bus.FlagsR), 72'(vecs[i].exp_flags));
    end

    // Flush while stalled, then three stalled cycles hold the bubble
    step(mk(1, 0, 4'd14, 2'b00, 4'h0, 1, 1, 1, 1, 0, 0, 32'h1234, 32'h5678, 4'd9, 1, 4'h4), "preflush");
    step(mk(0, 1, 4'd14, 2'b11, 4'hF, 0, 1, 0, 0, 0, 0, 32'hAAAA, 32'hBBBB, 4'd1, 1, 4'h4), "flush");
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 4'd14, 2'b11, 4'hF, 1, 1, 1, 1, 1, 0, 32'($urandom), 32'($urandom),
              4'($urandom_range(0, 15)), 1, 4'h4), $sformatf("stall%0d", i));

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
             4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'($urandom), 32'($urandom), 4'($urandom_range(0, 15)), 0, 4'h0);
      step(v, $sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-run with flags all set and a write in flight
    step(mk(1, 0, 4'd14, 2'b11, 4'hF, 0, 1, 0, 0, 0, 0, 32'h77, 32'h88, 4'd2, 1, 4'hF), "prereset");
    check("prereset RegWriteM", 72'(bus.RegWriteM), 72'h1);
    bus.CondE = 4'd1;
    bus.BranchE = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset FlagsR", 72'(bus.FlagsR), 72'h0);
    check("async reset M regs", dut_m(), 72'h0);
    check("async reset CondExE(NE)", 72'(bus.CondExE), 72'h1);
    check("async reset BranchTakenE", 72'(bus.BranchTakenE), 72'h1);
    flags_model = '0;
    m_model = '0;
    bus.EN = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post reset M regs", dut_m(), 72'h0);
    step(mk(1, 0, 4'd0, 2'b00, 4'h0, 0, 1, 0, 0, 0, 0, 32'h3, 32'h4, 4'd5, 0, 4'h0), "postreset");

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
